// File: rtl/uart_pkt_ctrl.sv
// Packet framer behind uart_rx: SYNC, ID, LEN, payload, XOR checksum (over ID..payload).
// Optional inter-byte gap timeout is enabled by defining UART_PKT_TIMEOUT_EN.
module uart_pkt_ctrl #(
  parameter logic [7:0] MY_ID       = 8'h03,
  parameter int         MAX_LEN     = 8,
  parameter logic [7:0] SYNC_BYTE   = 8'hAA,
  parameter int         TIMEOUT_CYC = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_flag,
  input  logic [7:0]           rx_byte,
  output logic                 pkt_valid,
  output logic [3:0]           pkt_len,
  output logic [MAX_LEN*8-1:0] pkt_data,
  output logic                 err_cksum,
  output logic                 err_frame,
  output logic                 busy
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ID_S  = 3'd1;
  localparam logic [2:0] LEN_S = 3'd2;
  localparam logic [2:0] PAY_S = 3'd3;
  localparam logic [2:0] CK_S  = 3'd4;

  logic [2:0] state;
  logic       flag_d;
  logic       acc;
  logic       drop;
  logic       tmo;
  logic [7:0] cksum;
  logic [3:0] count;
  logic [3:0] len;

  logic [MAX_LEN-1:0][7:0] shadow;
  logic [MAX_LEN-1:0][7:0] shadow_msk;
  logic [MAX_LEN-1:0][7:0] pkt_q;

  // Rising edge of rx_flag: a level-style flag held high is taken once.
  assign acc      = rx_flag & ~flag_d;
  assign busy     = (state != IDLE);
  assign pkt_data = pkt_q;

`ifdef UART_PKT_TIMEOUT_EN
  localparam int GW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  logic [GW-1:0] gap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     gap <= '0;
    else if (state == IDLE || acc)  gap <= '0;
    else                            gap <= gap + 1'b1;
  end

  assign tmo = (state != IDLE) && !acc && (gap == GW'(TIMEOUT_CYC - 1));
`else
  assign tmo = 1'b0;
`endif

  // Per-slot shadow storage; slots beyond len are masked on commit so stale
  // bytes from a longer earlier packet never leak into pkt_data.
  for (genvar i = 0; i < MAX_LEN; i++) begin : g_slot
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        shadow[i] <= 8'h00;
      else if (acc && state == PAY_S && count == 4'(i))
        shadow[i] <= rx_byte;
    end
    assign shadow_msk[i] = (4'(i) < len) ? shadow[i] : 8'h00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      flag_d    <= 1'b0;
      drop      <= 1'b0;
      cksum     <= 8'h00;
      count     <= 4'd0;
      len       <= 4'd0;
      pkt_valid <= 1'b0;
      err_cksum <= 1'b0;
      err_frame <= 1'b0;
      pkt_len   <= 4'd0;
      pkt_q     <= '0;
    end else begin
      flag_d    <= rx_flag;
      pkt_valid <= 1'b0;
      err_cksum <= 1'b0;
      err_frame <= 1'b0;
      if (acc) begin
        case (state)
          IDLE: if (rx_byte == SYNC_BYTE) state <= ID_S;
          ID_S: begin
            cksum <= rx_byte;
            drop  <= (rx_byte != MY_ID) && (rx_byte != 8'hFF);
            state <= LEN_S;
          end
          LEN_S: begin
            if (rx_byte == 8'h00 || rx_byte > 8'(MAX_LEN)) begin
              err_frame <= 1'b1;
              state     <= IDLE;
            end else begin
              len   <= rx_byte[3:0];
              count <= 4'd0;
              cksum <= cksum ^ rx_byte;
              state <= PAY_S;
            end
          end
          PAY_S: begin
            cksum <= cksum ^ rx_byte;
            count <= count + 4'd1;
            if (count == len - 4'd1) state <= CK_S;
          end
          CK_S: begin
            if (rx_byte != cksum) begin
              err_cksum <= 1'b1;
            end else if (!drop) begin
              pkt_q     <= shadow_msk;
              pkt_len   <= len;
              pkt_valid <= 1'b1;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end else if (tmo) begin
        err_frame <= 1'b1;
        state     <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_uart_pkt_ctrl.sv
// Scoreboard bench for uart_pkt_ctrl: expected strobes are queued at stimulus
// time and a negedge monitor pops and compares whenever any strobe fires.
module tb_uart_pkt_ctrl;

  localparam int MAX_LEN = 8;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 rx_flag = 1'b0;
  logic [7:0]           rx_byte = 8'h00;
  logic                 pkt_valid;
  logic [3:0]           pkt_len;
  logic [MAX_LEN*8-1:0] pkt_data;
  logic                 err_cksum;
  logic                 err_frame;
  logic                 busy;

  uart_pkt_ctrl #(
    .MY_ID(8'h03), .MAX_LEN(MAX_LEN), .SYNC_BYTE(8'hAA), .TIMEOUT_CYC(1024)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_flag(rx_flag), .rx_byte(rx_byte),
    .pkt_valid(pkt_valid), .pkt_len(pkt_len), .pkt_data(pkt_data),
    .err_cksum(err_cksum), .err_frame(err_frame), .busy(busy)
  );

  always #5 clk = ~clk;

  // kind is one-hot {pkt_valid, err_cksum, err_frame}
  typedef struct packed {
    logic [2:0]  kind;
    logic [3:0]  len;
    logic [63:0] data;
  } exp_t;

  typedef logic [7:0] byte_q_t[$];

  localparam logic [2:0] K_PKT = 3'b100;
  localparam logic [2:0] K_CK  = 3'b010;
  localparam logic [2:0] K_FR  = 3'b001;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic expect_evt(input logic [2:0] k, input logic [3:0] l, input logic [63:0] d);
    exp_t e;
    e.kind = k; e.len = l; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold);
    @(posedge clk); #1;
    rx_byte = b;
    rx_flag = 1'b1;
    repeat (hold) @(posedge clk);
    #1 rx_flag = 1'b0;
    repeat (8) @(posedge clk);
  endtask

  task automatic send_seq(input byte_q_t s, input int hold);
    foreach (s[i]) send_byte(s[i], hold);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    check({name, "_drain"}, 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: every strobe must match the head of the expectation queue.
  always @(negedge clk) begin
    if (rst_n && (pkt_valid || err_cksum || err_frame)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: actual={v,ck,fr}=%b required=none",
                 {pkt_valid, err_cksum, err_frame});
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("strobe_kind", 64'({pkt_valid, err_cksum, err_frame}), 64'(e.kind));
        if (e.kind == K_PKT) begin
          check("pkt_len", 64'(pkt_len), 64'(e.len));
          check("pkt_data", pkt_data, e.data);
        end
      end
    end
  end

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_pkt_len", 64'(pkt_len), 64'd0);
    check("rst_pkt_data", pkt_data, 64'd0);
    check("rst_strobes", 64'({pkt_valid, err_cksum, err_frame}), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // good packet, noise byte in IDLE ignored first
    send_byte(8'h55, 1);
    expect_evt(K_PKT, 4'd2, 64'h2211);
    send_seq('{8'hAA, 8'h03, 8'h02, 8'h11, 8'h22, 8'h32}, 1);
    drain("good");

    // bad checksum: outputs retain previous packet
    expect_evt(K_CK, 4'd0, 64'd0);
    send_seq('{8'hAA, 8'h03, 8'h02, 8'h11, 8'h22, 8'h33}, 1);
    drain("bad_ck");
    check("hold_pkt_len", 64'(pkt_len), 64'd2);
    check("hold_pkt_data", pkt_data, 64'h2211);

    // foreign ID: silent drop
    send_seq('{8'hAA, 8'h05, 8'h01, 8'h7E}, 1);
    check("foreign_busy_mid", 64'(busy), 64'd1);
    send_byte(8'h7A, 1);
    check("foreign_busy_end", 64'(busy), 64'd0);

    // broadcast
    expect_evt(K_PKT, 4'd1, 64'h7E);
    send_seq('{8'hAA, 8'hFF, 8'h01, 8'h7E, 8'h80}, 1);
    drain("bcast");

    // LEN boundaries
    expect_evt(K_FR, 4'd0, 64'd0);
    send_seq('{8'hAA, 8'h03, 8'h00}, 1);
    check("len0_busy", 64'(busy), 64'd0);
    expect_evt(K_FR, 4'd0, 64'd0);
    send_seq('{8'hAA, 8'h03, 8'h09}, 1);
    check("len9_busy", 64'(busy), 64'd0);
    drain("len_err");

    // maximum length, then a short packet must zero upper slots
    expect_evt(K_PKT, 4'd8, 64'h0807060504030201);
    send_seq('{8'hAA, 8'h03, 8'h08, 8'h01, 8'h02, 8'h03, 8'h04,
               8'h05, 8'h06, 8'h07, 8'h08, 8'h03}, 1);
    expect_evt(K_PKT, 4'd1, 64'h5A);
    send_seq('{8'hAA, 8'h03, 8'h01, 8'h5A, 8'h58}, 1);
    drain("maxlen");

    // level-style flag held 5 cycles; SYNC value as payload
    expect_evt(K_PKT, 4'd1, 64'hAA);
    send_seq('{8'hAA, 8'h03, 8'h01, 8'hAA, 8'hA8}, 5);
    drain("held");

    // asynchronous reset mid-packet
    send_seq('{8'hAA, 8'h03, 8'h02, 8'h11}, 1);
    check("mid_busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_pkt_data", pkt_data, 64'd0);
    check("arst_pkt_len", 64'(pkt_len), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    expect_evt(K_PKT, 4'd2, 64'h2211);
    send_seq('{8'hAA, 8'h03, 8'h02, 8'h11, 8'h22, 8'h32}, 1);
    drain("after_rst");

`ifdef UART_PKT_TIMEOUT_EN
    expect_evt(K_FR, 4'd0, 64'd0);
    send_seq('{8'hAA, 8'h03}, 1);
    drain("timeout");
    @(negedge clk);
    check("timeout_busy", 64'(busy), 64'd0);
`endif

    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_pkt_ctrl.md
Name: uart_pkt_ctrl

Overview:
Byte-level packet controller placed behind uart_rx. It consumes the receiver's flag/data_byte stream and frames robot command packets of the form SYNC, ID, LEN, payload, checksum. Accepted payloads are latched and announced with a one-cycle strobe; malformed packets raise error strobes. All downstream command logic reads from this block only, never from uart_rx directly.

Parameters:
MY_ID, 8'h03, this bot's address; ID 8'hFF (broadcast) is also accepted
MAX_LEN, 8, maximum payload bytes, range 1..15
SYNC_BYTE, 8'hAA, start-of-packet marker
TIMEOUT_CYC, 1024, idle clocks allowed between bytes inside a packet (used only with UART_PKT_TIMEOUT_EN)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rx_flag  in  1  uart_rx byte-ready flag; pulse or level
rx_byte  in  8  uart_rx data_byte
pkt_valid  out  1  one-cycle strobe: new packet latched on pkt_len/pkt_data
pkt_len  out  4  payload length of last good packet
pkt_data  out  MAX_LEN*8  payload; byte i on [8i+7:8i]
err_cksum  out  1  one-cycle strobe: checksum mismatch
err_frame  out  1  one-cycle strobe: bad LEN or timeout
busy  out  1  high while state != IDLE

Behaviour:
- Reset (async, rst_n low): state IDLE; pkt_valid, err_cksum, err_frame, busy = 0; pkt_len = 0; pkt_data = 0; internal flag_d = 0, cksum = 0, count = 0.
- Byte acceptance: a byte is accepted in cycle N when rx_flag=1 and registered flag_d=0 (rising edge). rx_flag held high for several cycles produces exactly one acceptance. rx_byte is sampled in cycle N.
- States:
  - IDLE: accepted byte == SYNC_BYTE -> ID_S; any other byte is ignored.
  - ID_S: accepted byte -> LEN_S; cksum <= byte; drop <= (byte != MY_ID && byte != 8'hFF).
  - LEN_S: byte == 0 or byte > MAX_LEN -> err_frame strobe, IDLE. Otherwise len <= byte[3:0], count <= 0, cksum ^= byte -> PAY_S.
  - PAY_S: byte stored in shadow buffer slot count; cksum ^= byte; count++; when count == len-1 on acceptance -> CK_S.
  - CK_S: accepted byte compared to cksum. Match and !drop: pkt_data <= shadow (slots >= len forced to 0), pkt_len <= len, pkt_valid strobe. Match and drop: no strobe. Mismatch: err_cksum strobe, regardless of drop. Always -> IDLE.
- Latency: strobes (pkt_valid, err_*) are registered and high for exactly cycle N+1, where N is the acceptance cycle of the deciding byte.
- Shadow buffer is separate from pkt_data. pkt_data/pkt_len change only on pkt_valid and hold otherwise.
- SYNC_BYTE inside ID/LEN/payload/checksum is treated as data. There is no resync mid-packet.
- busy is combinational from state (state != IDLE).
- rst_n asserted mid-packet: immediate return to IDLE; partial payload is discarded; pkt_data is cleared to 0.

Optional Feature:
UART_PKT_TIMEOUT_EN. When defined, a gap counter resets on each accepted byte and increments every clk while state != IDLE. When it reaches TIMEOUT_CYC-1 with no byte accepted, the block strobes err_frame and returns to IDLE; the shadow buffer is discarded. When undefined, there is no counter, and the block waits indefinitely in any state.

Test Plan:
- MY_ID=3, send AA 03 02 11 22 32 (8 clk/bit) -> one pkt_valid strobe; pkt_len=2; pkt_data[7:0]=11, [15:8]=22, upper bytes 0; no error strobes.
- Same packet with checksum 33 -> err_cksum single strobe; pkt_valid stays 0; pkt_len/pkt_data retain their previous values.
- AA 05 01 7E 7A (foreign ID) -> no strobes; busy returns 0 after the last byte. Then AA FF 01 7E 80 -> pkt_valid, pkt_len=1, pkt_data[7:0]=7E.
- AA 03 00 and AA 03 09 (MAX_LEN=8) -> err_frame strobe after the LEN byte; the next AA starts a fresh packet.
- rx_flag held high for 5 cycles per byte while sending AA 03 01 AA A8 -> accepted as one packet; payload AA; pkt_valid once.
- rst_n pulsed low after AA 03 02 11 -> state IDLE, pkt_data=0 immediately. With UART_PKT_TIMEOUT_EN and TIMEOUT_CYC=1024: stalling 1024 clk after AA 03 -> err_frame, busy=0.
